bf16_mult_sched: RTL and testbench
==================================

# bf16_mult_sched

Round-robin scheduler sharing one multi-cycle bfloat16 multiplier between `N_REQ` requesters. Accepts one operand pair at a time, launches the multiplier, holds operands stable, waits for its `ready`, returns the product tagged with the requester index. A watchdog converts a stalled multiplication into an error response.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 32: max WAIT cycles before error response, ≥ 4.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk`.
- `req_valid` in N_REQ: per-requester request.
- `req_a`, `req_b` in 16*N_REQ: bf16 operands; requester i at bits [16i+15:16i].
- `req_ready` out N_REQ: one-hot grant / accept strobe.
- `mult_a`, `mult_b` out 16: operands to the multiplier.
- `mult_launch` out 1: one-cycle pulse restarting the multiplier sequence.
- `mult_out` in 16: multiplier product.
- `mult_ready` in 1: multiplier result valid.
- `rsp_valid` out 1: response valid.
- `rsp_data` out 16: product, or qNaN on error.
- `rsp_id` out $clog2(N_REQ): index of the originating requester.
- `rsp_err` out 1: 1 means timeout.
- `rsp_ready` in 1: consumer accepts response.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: `req_ready` is combinationally one-hot to the round-robin winner among asserted `req_valid`; all zeros if none. On accept, latch the winner's operands into `mult_a`/`mult_b`, store its index, and go to LAUNCH.
- Round robin: search starts at `last_grant+1` and wraps modulo N_REQ. `last_grant` updates only on accept.
- LAUNCH: `mult_launch`=1 for exactly this cycle. Clear the watchdog. Go to WAIT. `mult_ready` is ignored in this state.
- WAIT: watchdog increments each cycle.
  - `mult_ready`=1: capture `mult_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Watchdog = TIMEOUT-1 and no `mult_ready`: set `rsp_data`=16'h7FC0 and `rsp_err`=1, go to RESP.
  - `mult_ready` and timeout in the same cycle: `mult_ready` wins, no error.
- RESP: `rsp_valid`=1. `rsp_data`, `rsp_id` and `rsp_err` stay stable until `rsp_ready`. On `rsp_valid & rsp_ready`, go to IDLE.
- `mult_a`/`mult_b` hold their values from accept until the next accept, including through RESP and IDLE.
- `mult_ready` pulses outside WAIT are ignored and never create a response.
- `req_valid` is not required to be held; only the accept cycle matters. A requester dropping `req_valid` early is simply not granted.

## Timing
- Reset (`reset`=0 at an edge):
  - state goes to IDLE and `last_grant` = N_REQ-1, so requester 0 has first priority.
  - `req_ready`, `mult_launch`, `rsp_valid` and `rsp_err` are 0.
  - `mult_a`, `mult_b`, `rsp_data` are 16'h0; `rsp_id` is 0.
- Reset mid-operation drops the in-flight request silently. No response is produced.
- Cycle 0: accept. Cycle 1: LAUNCH. From cycle 2: WAIT.
- If `mult_ready` is first high in cycle k ≥ 2, `rsp_valid` rises in cycle k+1.
- Minimum accept-to-`rsp_valid` is 3 cycles. Timeout path is TIMEOUT+2 cycles.
- Throughput: at most one request in flight. The next accept happens, at earliest, in the cycle after the response handshake.

## Structure
- Shared package `bf16_pkg`:
  - `BF16_QNAN` = 16'h7FC0.
  - `BF16_W` = 16.
  - state enum type `sched_state_t` {IDLE, LAUNCH, WAIT, RESP}.
- One sub-module `rr_pick`: combinational round-robin selector. Inputs: request vector and `last_grant`. Outputs: one-hot grant and index.
- The multiplier is instantiated by the parent; this block only drives and receives its ports.

## Test plan
- Single request: reset, then req 2 with a=16'h3F80 (1.0), b=16'h4000 (2.0). Mult model returns 16'h4000 with `mult_ready` 4 cycles after launch -> `rsp_valid` with `rsp_data`=16'h4000, `rsp_id`=2, `rsp_err`=0; exactly one `mult_launch` pulse.
- Round robin: all four `req_valid` held high, `rsp_ready`=1 -> grants in order 0,1,2,3,0, each accepted only after the previous response.
- Timeout: model never asserts `mult_ready` -> `rsp_valid` TIMEOUT+2 cycles after accept with `rsp_data`=16'h7FC0 and `rsp_err`=1.
- Tie and backpressure: `mult_ready` asserted in the last WAIT cycle -> `rsp_err`=0. Hold `rsp_ready`=0 for 5 cycles -> response fields stable and no new `req_ready`.
- Spurious ready and reset: `mult_ready` pulsed in IDLE -> no response. Assert `reset`=0 during WAIT -> all outputs return to reset values next edge; a later `mult_ready` produces no response.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants and the scheduler state encoding.
package bf16_pkg;

   localparam int unsigned BF16_W = 16;
   localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FC0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request after last_grant, wrapping.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned IDW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last_grant,
   output logic [N_REQ-1:0] gnt_c,
   output logic [IDW-1:0]   idx_c,
   output logic             any_c
);

   logic [IDW-1:0] cand;

   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      any_c = 1'b0;
      cand  = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = IDW'((32'(last_grant) + i) % N_REQ);
         if (!any_c && req[cand]) begin
            any_c       = 1'b1;
            idx_c       = cand;
            gnt_c[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bf16_mult_sched.sv
// Round-robin scheduler sharing one multi-cycle bf16 multiplier, with a watchdog
// that turns a stalled multiplication into a qNaN error response.
module bf16_mult_sched
   import bf16_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 32,
   localparam int unsigned IDW = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [BF16_W*N_REQ-1:0] req_a,
   input  logic [BF16_W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]        req_ready,
   output logic [BF16_W-1:0]       mult_a,
   output logic [BF16_W-1:0]       mult_b,
   output logic                    mult_launch,
   input  logic [BF16_W-1:0]       mult_out,
   input  logic                    mult_ready,
   output logic                    rsp_valid,
   output logic [BF16_W-1:0]       rsp_data,
   output logic [IDW-1:0]          rsp_id,
   output logic                    rsp_err,
   input  logic                    rsp_ready
);

   localparam int unsigned WDW = $clog2(TIMEOUT);

   sched_state_t      state_q, state_d;
   logic [IDW-1:0]    last_q, last_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [BF16_W-1:0] a_q, a_d, b_q, b_d;
   logic [BF16_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic [WDW-1:0]    wd_q, wd_d;

   logic [N_REQ-1:0]  gnt_c;
   logic [IDW-1:0]    pick_idx_c;
   logic              pick_any_c;
   logic              accept_c;
   logic [BF16_W-1:0] sel_a_c, sel_b_c;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_q),
      .gnt_c      (gnt_c),
      .idx_c      (pick_idx_c),
      .any_c      (pick_any_c)
   );

   // Operand mux driven by the one-hot grant.
   always_comb begin
      sel_a_c = '0;
      sel_b_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt_c[i]) begin
            sel_a_c = req_a[i*BF16_W +: BF16_W];
            sel_b_c = req_b[i*BF16_W +: BF16_W];
         end
      end
   end

   assign accept_c  = (state_q == IDLE) && pick_any_c;
   assign req_ready = (state_q == IDLE) ? gnt_c : '0;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      err_d   = err_q;
      wd_d    = wd_q;
      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               a_d     = sel_a_c;
               b_d     = sel_b_c;
               id_d    = pick_idx_c;
               last_d  = pick_idx_c;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A ready arriving on the final watchdog cycle still counts as success.
            if (mult_ready) begin
               data_d  = mult_out;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (wd_q == WDW'(TIMEOUT - 1)) begin
               data_d  = BF16_QNAN;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= IDW'(N_REQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
      end
   end

   assign mult_a      = a_q;
   assign mult_b      = b_q;
   assign mult_launch = (state_q == LAUNCH);
   assign rsp_valid   = (state_q == RESP);
   assign rsp_data    = data_q;
   assign rsp_id      = id_q;
   assign rsp_err     = err_q;

endmodule

// File: tb/tb_bf16_mult_sched.sv
// Directed bench for bf16_mult_sched: single op, round robin, timeout, tie, backpressure, reset.
module tb_bf16_mult_sched;

   localparam int unsigned N  = 4;
   localparam int unsigned TO = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req_valid;
   logic [16*N-1:0] req_a, req_b;
   logic [N-1:0]  req_ready;
   logic [15:0]   mult_a, mult_b, mult_out, rsp_data;
   logic          mult_launch, mult_ready, rsp_valid, rsp_err, rsp_ready;
   logic [1:0]    rsp_id;

   int total = 0;
   int bad   = 0;
   int launches = 0;

   bf16_mult_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b), .mult_launch(mult_launch),
      .mult_out(mult_out), .mult_ready(mult_ready), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mult_launch === 1'b1) launches <= launches + 1;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic ok;
      logic [1:0] order [5];
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

      reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      mult_out = '0; mult_ready = 1'b0; rsp_ready = 1'b0;
      tick(); tick();
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_launch", 32'(mult_launch), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_mult_a", 32'(mult_a), 0);
      chk("rst_mult_b", 32'(mult_b), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      reset = 1'b1;

      // Single request from requester 2: 1.0 * 2.0
      req_valid = 4'b0100;
      req_a[47:32] = 16'h3F80;
      req_b[47:32] = 16'h4000;
      #1;
      chk("single_grant", 32'(req_ready), 32'h4);
      tick();                      // cycle 1: LAUNCH
      req_valid = '0;
      #1;
      chk("single_launch", 32'(mult_launch), 1);
      chk("single_mult_a", 32'(mult_a), 32'h3F80);
      chk("single_mult_b", 32'(mult_b), 32'h4000);
      chk("single_busy_noready", 32'(req_ready), 0);
      tick();                      // cycle 2
      chk("single_launch_once", 32'(mult_launch), 0);
      tick(); tick(); tick();      // cycle 5: ready 4 cycles after launch
      chk("single_not_early", 32'(rsp_valid), 0);
      mult_ready = 1'b1; mult_out = 16'h4000;
      tick();                      // cycle 6: RESP
      mult_ready = 1'b0;
      #1;
      chk("single_rsp_valid", 32'(rsp_valid), 1);
      chk("single_rsp_data", 32'(rsp_data), 32'h4000);
      chk("single_rsp_id", 32'(rsp_id), 2);
      chk("single_rsp_err", 32'(rsp_err), 0);
      chk("single_launch_count", 32'(launches), 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      chk("single_back_idle", 32'(rsp_valid), 0);
      chk("single_hold_mult_a", 32'(mult_a), 32'h3F80);

      // Round robin with all requesters active
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_a[16*i +: 16] = 16'h1000 + 16'(i);
         req_b[16*i +: 16] = 16'h2000 + 16'(i);
      end
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         #1;
         chk("rr_grant", 32'(req_ready), 32'(4'b0001 << order[g]));
         tick();
         chk("rr_mult_a", 32'(mult_a), 32'h1000 + 32'(order[g]));
         chk("rr_no_grant_busy", 32'(req_ready), 0);
         tick();
         mult_ready = 1'b1; mult_out = 16'h3000 + 16'(g);
         tick();
         mult_ready = 1'b0;
         #1;
         chk("rr_rsp_id", 32'(rsp_id), 32'(order[g]));
         chk("rr_rsp_data", 32'(rsp_data), 32'h3000 + 32'(g));
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b0;

      // Timeout: multiplier never answers
      do_reset();
      req_valid = 4'b0001;
      #1;
      tick();                      // cycle 1
      req_valid = '0;
      ok = 1'b1;
      for (int c = 1; c <= int'(TO) + 1; c++) begin
         if (c > 1) tick();
         if (rsp_valid !== 1'b0) ok = 1'b0;
      end
      chk("to_no_early_rsp", 32'(ok), 1);
      tick();                      // cycle TO+2
      chk("to_rsp_valid", 32'(rsp_valid), 1);
      chk("to_rsp_data", 32'(rsp_data), 32'h7FC0);
      chk("to_rsp_err", 32'(rsp_err), 1);
      chk("to_rsp_id", 32'(rsp_id), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Tie: ready on the last WAIT cycle wins over the watchdog
      req_valid = 4'b0010;
      #1;
      chk("tie_grant", 32'(req_ready), 32'h2);
      tick();                      // cycle 1
      req_valid = '0;
      for (int c = 2; c <= int'(TO) + 1; c++) tick();
      mult_ready = 1'b1; mult_out = 16'h4040;   // cycle TO+1
      tick();
      mult_ready = 1'b0;
      #1;
      chk("tie_rsp_valid", 32'(rsp_valid), 1);
      chk("tie_rsp_err", 32'(rsp_err), 0);
      chk("tie_rsp_data", 32'(rsp_data), 32'h4040);
      chk("tie_rsp_id", 32'(rsp_id), 1);

      // Backpressure: response held, no grants
      req_valid = 4'b1111;
      ok = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== 16'h4040 || rsp_id !== 2'd1 ||
             rsp_err !== 1'b0 || req_ready !== 4'b0000) ok = 1'b0;
      end
      chk("bp_stable", 32'(ok), 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      chk("bp_next_grant", 32'(req_ready), 32'h4);
      req_valid = '0;
      #1;

      // Spurious multiplier ready while idle
      mult_ready = 1'b1; mult_out = 16'h1234;
      tick();
      mult_ready = 1'b0;
      tick();
      chk("spur_no_rsp", 32'(rsp_valid), 0);
      chk("spur_no_launch", 32'(mult_launch), 0);

      // Reset during WAIT drops the request
      req_valid = 4'b0001;
      req_a[15:0] = 16'h4110; req_b[15:0] = 16'h4220;
      #1;
      tick();
      req_valid = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      #1;
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rst_launch", 32'(mult_launch), 0);
      chk("mid_rst_mult_a", 32'(mult_a), 0);
      chk("mid_rst_rsp_data", 32'(rsp_data), 0);
      chk("mid_rst_rsp_id", 32'(rsp_id), 0);
      chk("mid_rst_rsp_err", 32'(rsp_err), 0);
      reset = 1'b1;
      mult_ready = 1'b1; mult_out = 16'h5555;
      tick();
      mult_ready = 1'b0;
      ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (rsp_valid !== 1'b0) ok = 1'b0;
      end
      chk("mid_rst_no_rsp", 32'(ok), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
